// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: synchronizes one PWM line, measures pulse width and frame
// period in clock ticks, classifies the width into a speed code, flags signal loss.
module servo_pwm_decoder #(
    parameter int CNT_W   = 8,
    parameter int MIN_W   = 5,
    parameter int MAX_W   = 25,
    parameter int SPLIT_W = 15,
    parameter int TIMEOUT = 250
) (
    input  logic             clk_10KHz,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       vel_code,
    output logic             meas_valid,
    output logic             sig_lost
);

    typedef enum logic [1:0] {IDLE, ARM_HIGH, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] width_cnt, period_cnt, idle_cnt, stored_w;
    logic             line, rise, fall, edge_det, timeout_hit;
    logic             publish, store_w;

    function automatic logic [1:0] speed_code(input logic [CNT_W-1:0] w);
        if (w < CNT_W'(MIN_W) || w > CNT_W'(MAX_W)) return 2'd3;
        else if (w < CNT_W'(SPLIT_W))                return 2'd1;
        else                                         return 2'd2;
    endfunction

    // Chain resets high so a line already high at reset release is not seen as a rise.
    always_ff @(posedge clk_10KHz or negedge rst_n) begin
        if (!rst_n) sync_q <= 3'b111;
        else        sync_q <= {sync_q[1:0], pwm_in};
    end

    assign line        = sync_q[1];
    assign rise        = sync_q[1] & ~sync_q[2];
    assign fall        = ~sync_q[1] & sync_q[2];
    assign edge_det    = rise | fall;
    assign timeout_hit = !edge_det && (idle_cnt == TIMEOUT_M1);

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        store_w = 1'b0;
        case (state_q)
            IDLE:     if (rise) state_d = ARM_HIGH;
            ARM_HIGH,
            HIGH:     if (fall) begin
                          store_w = 1'b1;
                          state_d = LOW;
                      end
            LOW:      if (rise) begin
                          publish = 1'b1;
                          state_d = HIGH;
                      end
            default:  state_d = IDLE;
        endcase
        // An edge on the same cycle blocks timeout_hit, so the edge always wins.
        if (timeout_hit) begin
            state_d = IDLE;
            publish = 1'b0;
            store_w = 1'b0;
        end
    end

    always_ff @(posedge clk_10KHz or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_10KHz or negedge rst_n) begin
        if (!rst_n) begin
            width_cnt  <= '0;
            period_cnt <= '0;
            idle_cnt   <= '0;
            stored_w   <= '0;
        end else begin
            if (rise)                              width_cnt <= CNT_W'(1);
            else if (line && width_cnt != CNT_MAX) width_cnt <= width_cnt + 1'b1;

            if (rise)                        period_cnt <= CNT_W'(1);
            else if (period_cnt != CNT_MAX)  period_cnt <= period_cnt + 1'b1;

            if (edge_det)                    idle_cnt <= '0;
            else if (idle_cnt != TIMEOUT_C)  idle_cnt <= idle_cnt + 1'b1;

            if (store_w) stored_w <= width_cnt;
        end
    end

    // Published period is the count reached just before the new rise reloads it.
    always_ff @(posedge clk_10KHz or negedge rst_n) begin
        if (!rst_n) begin
            width      <= '0;
            period     <= '0;
            vel_code   <= 2'd0;
            meas_valid <= 1'b0;
            sig_lost   <= 1'b1;
        end else begin
            meas_valid <= publish;
            if (publish) begin
                width  <= stored_w;
                period <= period_cnt;
            end
            if (timeout_hit)  vel_code <= 2'd0;
            else if (publish) vel_code <= speed_code(stored_w);
            if (timeout_hit)  sig_lost <= 1'b1;
            else if (rise)    sig_lost <= 1'b0;
        end
    end

endmodule
